// File: rtl/dmem_access_unit_if.sv
// Bundle of the core-side request/response and data-memory bus signals of the load/store unit.
// master = the load/store unit itself, slave = the core/memory environment around it.
interface dmem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output stall, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  stall, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// RISC-V load/store unit: one data-memory access per decoded load/store over req/gnt/rvalid,
// with byte enables, store-lane replication, load extension and misalignment reporting.
module dmem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_access_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              signed_q, signed_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              misaligned;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic [31:0]       lane;
  logic [31:0]       load_ext;

  // Decode of the request presented by the core this cycle.
  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b0000;
    wdata_new  = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be_new    = 4'b0001 << bus.req_addr[1:0];
        wdata_new = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be_new     = 4'b0011 << {bus.req_addr[1], 1'b0};
        wdata_new  = {2{bus.req_wdata[15:0]}};
        misaligned = bus.req_addr[0];
      end
      2'b10: begin
        be_new     = 4'b1111;
        misaligned = |bus.req_addr[1:0];
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Load lane extraction from the returned word, using the latched size/offset/signedness.
  always_comb begin
    lane = bus.mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{signed_q & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    size_d      = size_q;
    off_d       = off_q;
    signed_d    = signed_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          size_d   = bus.req_size;
          off_d    = bus.req_addr[1:0];
          signed_d = bus.req_signed;
          if (misaligned) begin
            // Memory is never touched; the error response comes straight back.
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
            state_d     = RESP;
          end else begin
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = wdata_new;
            mem_be_d    = be_new;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          rsp_rdata_d = mem_we_q ? 32'h0 : load_ext;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      signed_q    <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      size_q      <= size_d;
      off_q       <= off_d;
      signed_q    <= signed_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Stall is gated by rst_n so it reads 0 while reset is held, even with req_valid high.
  assign bus.stall     = rst_n && (state_q != RESP) && (bus.req_valid || (state_q != IDLE));
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: hand-computed loads, stores, misaligned cases,
// back-to-back accesses and reset in the middle of a memory request.
module tb_dmem_access_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  dmem_access_unit_if #(.ADDR_W(32)) bus ();

  dmem_access_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one access, plays the memory (gnt after gnt_delay REQ cycles, rvalid in WAIT),
  // and checks every cycle from accept (cycle 0) through RESP.
  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gnt_delay,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_cyc);
    int cyc;
    int n_req;
    bit granted;
    bit done;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    #1;
    check({tag, ":stall_c0"}, 32'(bus.stall), 32'd1);
    check({tag, ":rsp_valid_c0"}, 32'(bus.rsp_valid), 32'd0);
    cyc = 0;
    n_req = 0;
    granted = 1'b0;
    done = 1'b0;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      #1;
      if (bus.rsp_valid) begin
        done = 1'b1;
        check({tag, ":rsp_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, ":rsp_rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, ":rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, ":stall_resp"}, 32'(bus.stall), 32'd0);
        check({tag, ":mem_req_resp"}, 32'(bus.mem_req), 32'd0);
      end else begin
        check({tag, ":stall"}, 32'(bus.stall), 32'd1);
        if (exp_err) begin
          check({tag, ":mem_req_err"}, 32'(bus.mem_req), 32'd0);
        end else if (bus.mem_req) begin
          check({tag, ":mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
          check({tag, ":mem_be"}, 32'(bus.mem_be), 32'(exp_be));
          check({tag, ":mem_we"}, 32'(bus.mem_we), 32'(we));
          check({tag, ":mem_wdata"}, bus.mem_wdata, exp_wdata);
          if (n_req == gnt_delay) begin
            bus.mem_gnt = 1'b1;
            granted = 1'b1;
          end
          n_req++;
        end else if (granted) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rdata;
        end
      end
    end
    check({tag, ":completed"}, 32'(done), 32'd1);
    $display("[TB] %s addr=0x%08h we=%0d size=%0d -> rdata=0x%08h err=%0d after %0d cycles",
             tag, addr, we, size, bus.rsp_rdata, bus.rsp_err, cyc);
  endtask

  // One cycle with no request: response pulse must be gone, data held.
  task automatic idle(input string tag, input logic [31:0] held_rdata);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    #1;
    check({tag, ":idle_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ":idle_stall"}, 32'(bus.stall), 32'd0);
    check({tag, ":idle_rdata_hold"}, bus.rsp_rdata, held_rdata);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;

    repeat (3) @(negedge clk);
    #1;
    check("rst:stall", 32'(bus.stall), 32'd0);
    check("rst:rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst:rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst:rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst:mem_req", 32'(bus.mem_req), 32'd0);
    check("rst:mem_we", 32'(bus.mem_we), 32'd0);
    check("rst:mem_addr", bus.mem_addr, 32'h0);
    check("rst:mem_wdata", bus.mem_wdata, 32'h0);
    check("rst:mem_be", 32'(bus.mem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //      tag     we    size   sgn   addr          wdata         rdata         gnt be       exp_wdata     exp_rdata     err cyc
    access("LB",   1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0000_0000, 32'h80FF_1234, 0, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80, 1'b0, 3);
    idle("LB", 32'hFFFF_FF80);
    access("LBU",  1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_0000, 32'h80FF_1234, 0, 4'b1000, 32'h0000_0000, 32'h0000_0080, 1'b0, 3);
    idle("LBU", 32'h0000_0080);
    access("LHU",  1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_0000, 32'h9ABC_5678, 0, 4'b1100, 32'h0000_0000, 32'h0000_9ABC, 1'b0, 3);
    idle("LHU", 32'h0000_9ABC);
    access("LH",   1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0000_0000, 32'h9ABC_5678, 0, 4'b1100, 32'h0000_0000, 32'hFFFF_9ABC, 1'b0, 3);
    idle("LH", 32'hFFFF_9ABC);
    access("SB",   1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'hDEAD_BEEF, 32'h5555_5555, 3, 4'b0010, 32'hEFEF_EFEF, 32'h0000_0000, 1'b0, 6);
    idle("SB", 32'h0000_0000);
    access("LWmis", 1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0000_0000, 32'h1234_5678, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1);
    access("SHmis", 1'b1, 2'b01, 1'b0, 32'h0000_4001, 32'hCAFE_F00D, 32'h1234_5678, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1);
    access("SZ11", 1'b0, 2'b11, 1'b0, 32'h0000_4000, 32'h0000_0000, 32'h1234_5678, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1);
    idle("mis", 32'h0000_0000);
    // Back-to-back: the second accept lands in the cycle right after the first RESP.
    access("SW",   1'b1, 2'b10, 1'b0, 32'h0000_5000, 32'h1122_3344, 32'h0000_0000, 0, 4'b1111, 32'h1122_3344, 32'h0000_0000, 1'b0, 3);
    access("LW",   1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0000_0000, 32'h1122_3344, 1, 4'b1111, 32'h0000_0000, 32'h1122_3344, 1'b0, 4);
    idle("LW", 32'h1122_3344);

    // Reset in the middle of a memory request.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0000_6000;
    @(negedge clk);
    #1;
    check("rstreq:mem_req_before", 32'(bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstreq:mem_req", 32'(bus.mem_req), 32'd0);
    check("rstreq:stall", 32'(bus.stall), 32'd0);
    check("rstreq:rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hA5A5_A5A5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      #1;
      check("rstreq:late_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rstreq:late_stall", 32'(bus.stall), 32'd0);
      check("rstreq:late_mem_req", 32'(bus.mem_req), 32'd0);
    end
    $display("[TB] reset during REQ, late rvalid -> rsp_valid=%0d", bus.rsp_valid);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
